// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: steps each instruction through FETCH/DECODE/EXE/MEM/WB
// and drives the datapath control strobes, plus halt/illegal/retired-count status.
//
// state  | meaning
// IDLE   | testbench owns memory, waiting for TBorNot=0
// FETCH  | load instruction register
// DECODE | opcode visible on InsM, latched at the end of this state
// EXE    | ALU / branch / jump work
// MEM    | memory access for LD/ST, data hold for LI/MOV
// WB     | register-file writeback and PC update
// HALT   | stopped until reset
module multicycle_ctrl #(
    parameter logic [4:0]  HALT_OPC = 5'h1F,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             TBorNot,
    input  logic [7:0]       InsM,
    input  logic [1:0]       InsL,
    input  logic [2:0]       PSW_NZC,
    output logic [1:0]       Jump,
    output logic             Branch,
    output logic             Buff_PC,
    output logic             WBresource,
    output logic             PCplus1orWB,
    output logic             RBresource,
    output logic             WE_RF,
    output logic             LI,
    output logic             oprandB,
    output logic             Flag,
    output logic             ALUop,
    output logic             Buff_PSW,
    output logic             Buff_OutR,
    output logic             MEMresource,
    output logic             LIorMOV,
    output logic             ALUorNot,
    output logic             Buff_MEMIns,
    output logic             WE_MEM,
    output logic [2:0]       State,
    output logic             Halted,
    output logic             Illegal,
    output logic [CNT_W-1:0] InsCount
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXE    = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [4:0] OP_RALU  = 5'd0;
    localparam logic [4:0] OP_IALU  = 5'd1;
    localparam logic [4:0] OP_LI    = 5'd2;
    localparam logic [4:0] OP_MOV   = 5'd3;
    localparam logic [4:0] OP_LD    = 5'd4;
    localparam logic [4:0] OP_ST    = 5'd5;
    localparam logic [4:0] OP_B     = 5'd6;
    localparam logic [4:0] OP_BCOND = 5'd7;
    localparam logic [4:0] OP_JAL   = 5'd8;
    localparam logic [4:0] OP_JR    = 5'd9;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    state_t           state_d;
    state_t           after_ins;
    logic [7:0]       ins_m_q;
    logic [1:0]       ins_l_q;
    logic [CNT_W-1:0] ins_count_q;
    logic [4:0]       opc_live;
    logic [4:0]       opc_q;
    logic [2:0]       cond_q;

    assign opc_live = InsM[7:3];
    assign opc_q    = ins_m_q[7:3];
    assign cond_q   = ins_m_q[2:0];
    assign State    = state_q;
    assign InsCount = ins_count_q;

    function automatic logic cond_true(input logic [2:0] cond, input logic [2:0] nzc);
        logic res;
        res = 1'b0;
        case (cond)
            3'b000:  res = nzc[1];
            3'b001:  res = ~nzc[1];
            3'b010:  res = nzc[0];
            3'b011:  res = ~nzc[0];
            3'b100:  res = nzc[2];
            3'b101:  res = ~nzc[2];
            3'b110:  res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (!Rst) begin
            state_q     <= S_IDLE;
            ins_m_q     <= '0;
            ins_l_q     <= '0;
            ins_count_q <= '0;
        end else begin
            state_q <= state_d;
            // IR is loaded at the FETCH->DECODE edge, so InsM is only valid from DECODE on
            if (state_q == S_DECODE) begin
                ins_m_q <= InsM;
                ins_l_q <= InsL;
            end
            if (Buff_PC) begin
                ins_count_q <= ins_count_q + CNT_ONE;
            end
        end
    end

    always_comb begin
        after_ins = TBorNot ? S_IDLE : S_FETCH;
        state_d   = state_q;
        case (state_q)
            S_IDLE:   if (!TBorNot) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = (opc_live == HALT_OPC) ? S_HALT : S_EXE;
            S_EXE: begin
                case (opc_q)
                    OP_RALU, OP_IALU, OP_LI, OP_MOV, OP_LD, OP_ST: state_d = S_MEM;
                    default: state_d = after_ins;
                endcase
            end
            S_MEM:    state_d = (opc_q == OP_ST) ? after_ins : S_WB;
            S_WB:     state_d = after_ins;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Strobes are forced low while Rst is asserted so an aborted instruction never writes
    always_comb begin
        Jump        = 2'b00;
        Branch      = 1'b0;
        Buff_PC     = 1'b0;
        WBresource  = 1'b0;
        PCplus1orWB = 1'b0;
        RBresource  = 1'b0;
        WE_RF       = 1'b0;
        LI          = 1'b0;
        oprandB     = 1'b0;
        Flag        = 1'b0;
        ALUop       = 1'b0;
        Buff_PSW    = 1'b0;
        Buff_OutR   = 1'b0;
        MEMresource = 1'b0;
        LIorMOV     = 1'b0;
        ALUorNot    = 1'b0;
        Buff_MEMIns = 1'b0;
        WE_MEM      = 1'b0;
        Halted      = 1'b0;
        Illegal     = 1'b0;
        if (Rst) begin
            case (state_q)
                S_FETCH: Buff_MEMIns = 1'b1;
                S_DECODE: Illegal = (opc_live > OP_JR) && (opc_live != HALT_OPC);
                S_EXE: begin
                    case (opc_q)
                        OP_RALU, OP_IALU: begin
                            ALUop    = ins_l_q[0];
                            Flag     = ins_l_q[1];
                            Buff_PSW = 1'b1;
                            oprandB  = (opc_q == OP_IALU);
                        end
                        OP_LI: begin
                            LI       = 1'b1;
                            ALUorNot = 1'b1;
                        end
                        OP_MOV: begin
                            Buff_OutR = 1'b1;
                            LIorMOV   = 1'b1;
                            ALUorNot  = 1'b1;
                        end
                        OP_LD: oprandB = 1'b1;
                        OP_ST: begin
                            RBresource = 1'b1;
                            oprandB    = 1'b1;
                        end
                        OP_B: begin
                            Jump    = 2'b01;
                            Buff_PC = 1'b1;
                        end
                        OP_BCOND: begin
                            Branch  = cond_true(cond_q, PSW_NZC);
                            Buff_PC = 1'b1;
                        end
                        OP_JAL: begin
                            Jump    = 2'b10;
                            WE_RF   = 1'b1;
                            Buff_PC = 1'b1;
                        end
                        OP_JR: begin
                            Jump    = 2'b11;
                            Buff_PC = 1'b1;
                        end
                        default: Buff_PC = 1'b1;
                    endcase
                end
                S_MEM: begin
                    case (opc_q)
                        OP_LI: begin
                            LI       = 1'b1;
                            ALUorNot = 1'b1;
                        end
                        OP_MOV: begin
                            LIorMOV  = 1'b1;
                            ALUorNot = 1'b1;
                        end
                        OP_LD: MEMresource = 1'b1;
                        OP_ST: begin
                            MEMresource = 1'b1;
                            WE_MEM      = 1'b1;
                            Buff_PC     = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_WB: begin
                    WE_RF   = 1'b1;
                    Buff_PC = 1'b1;
                    if (opc_q == OP_LD) begin
                        WBresource = 1'b1;
                    end else begin
                        PCplus1orWB = 1'b1;
                    end
                end
                S_HALT: Halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
